// File: rtl/sbox_ced_pipe.sv
// sbox_ced_pipe: multi-lane, two-stage pipelined AES forward S-box with
// concurrent error detection. Each input byte's even parity is checked on
// entry, and each output byte's parity is predicted from a separate 256x1
// table that is built from the GF(2^8) inverse, not from the S-box table.
// A mismatch on any lane raises Err_SO, which feeds the sticky lane flags
// and the saturating error-event counter.
//
// Optional feature macro: SBOX_CED_FAULT_INJ_EN
//   When defined, adds FaultMask_DI. The mask is XORed into the stage-2 bytes
//   before they drive Out_DO and before the output parity check, while
//   OutPar_DO is left untouched. This exercises the alarm path.

module sbox_ced_pipe #(
    parameter int LANES = 4,
    parameter int CNT_W = 8
) (
    input  logic                 Clk_CI,
    input  logic                 Rst_RI,
    input  logic                 InValid_SI,
    output logic                 InReady_SO,
    input  logic [8*LANES-1:0]   In_DI,
    input  logic [LANES-1:0]     InPar_DI,
`ifdef SBOX_CED_FAULT_INJ_EN
    input  logic [8*LANES-1:0]   FaultMask_DI,
`endif
    output logic                 OutValid_SO,
    input  logic                 OutReady_SI,
    output logic [8*LANES-1:0]   Out_DO,
    output logic [LANES-1:0]     OutPar_DO,
    output logic                 Err_SO,
    output logic [LANES-1:0]     ErrLane_DO,
    output logic [CNT_W-1:0]     ErrCnt_DO,
    input  logic                 ErrClr_SI
);

    // ------------------------------------------------------------------
    // Forward AES S-box lookup table, indexed by the input byte.
    // ------------------------------------------------------------------
    localparam logic [7:0] SBOX_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // GF(2^8) multiply modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] prod;
        logic [7:0] acc;
        prod = 8'h00;
        acc  = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) begin
                prod = prod ^ acc;
            end
            acc = {acc[6:0], 1'b0} ^ (acc[7] ? 8'h1b : 8'h00);
        end
        return prod;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] res;
        logic [7:0] base;
        logic [7:0] expo;
        res  = 8'h01;
        base = a;
        expo = 8'd254;
        for (int k = 0; k < 8; k++) begin
            if (expo[k]) begin
                res = gf_mul(res, base);
            end
            base = gf_mul(base, base);
        end
        return res;
    endfunction

    // Every column of the S-box affine matrix has odd weight and the constant
    // 0x63 has even weight, so parity(SBOX(x)) equals parity(inverse(x)).
    // This gives a parity-prediction table independent of SBOX_TABLE.
    function automatic logic [255:0] build_ppar();
        logic [255:0] tbl;
        tbl = '0;
        for (int i = 0; i < 256; i++) begin
            tbl[i] = ^gf_inv(8'(i));
        end
        return tbl;
    endfunction

    localparam logic [255:0]     PPAR_TABLE = build_ppar();
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic                 s1_valid;
    logic [8*LANES-1:0]   s1_data;
    logic [LANES-1:0]     s1_inerr;
    logic [8*LANES-1:0]   s2_data;
    logic [LANES-1:0]     s2_par;
    logic [LANES-1:0]     s2_inerr;

    logic                 s2_hold;
    logic                 in_ready;
    logic [LANES-1:0]     in_err;
    logic [8*LANES-1:0]   sub_bytes;
    logic [LANES-1:0]     pred_par;
    logic [8*LANES-1:0]   out_bytes;
    logic [LANES-1:0]     lane_err;
    logic                 err_xfer;

    // Handshake control: stage 2 stalls on backpressure, stage 1 only stalls
    // when it is full and stage 2 cannot drain.
    always_comb begin
        s2_hold    = OutValid_SO & ~OutReady_SI;
        in_ready   = ~s1_valid | ~s2_hold;
        InReady_SO = in_ready;
    end

    // Input parity check and per-lane lookups of the S-box and parity tables.
    always_comb begin
        in_err    = '0;
        sub_bytes = '0;
        pred_par  = '0;
        for (int i = 0; i < LANES; i++) begin
            in_err[i]          = (^In_DI[8*i +: 8]) ^ InPar_DI[i];
            sub_bytes[8*i +: 8] = SBOX_TABLE[s1_data[8*i +: 8]];
            pred_par[i]        = PPAR_TABLE[s1_data[8*i +: 8]];
        end
    end

    // Stage 1 register: captures the input word and its parity-check result.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_inerr <= '0;
        end else if (in_ready) begin
            s1_valid <= InValid_SI;
            if (InValid_SI) begin
                s1_data  <= In_DI;
                s1_inerr <= in_err;
            end
        end
    end

    // Stage 2 register: captures substituted bytes and predicted parity.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            OutValid_SO <= 1'b0;
            s2_data     <= '0;
            s2_par      <= '0;
            s2_inerr    <= '0;
        end else if (!s2_hold) begin
            OutValid_SO <= s1_valid;
            if (s1_valid) begin
                s2_data  <= sub_bytes;
                s2_par   <= pred_par;
                s2_inerr <= s1_inerr;
            end
        end
    end

    // Output bytes (optionally fault-masked) and per-lane error detection.
    always_comb begin
`ifdef SBOX_CED_FAULT_INJ_EN
        out_bytes = s2_data ^ FaultMask_DI;
`else
        out_bytes = s2_data;
`endif
        lane_err = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_err[i] = s2_inerr[i] | ((^out_bytes[8*i +: 8]) ^ s2_par[i]);
        end
        Out_DO    = out_bytes;
        OutPar_DO = s2_par;
        Err_SO    = OutValid_SO & (|lane_err);
        err_xfer  = OutValid_SO & OutReady_SI & Err_SO;
    end

    // Error accounting: sticky lane flags and saturating event counter,
    // updated only when an erroneous word is actually handed downstream.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            ErrLane_DO <= '0;
            ErrCnt_DO  <= '0;
        end else if (ErrClr_SI) begin
            ErrLane_DO <= err_xfer ? lane_err : '0;
            ErrCnt_DO  <= err_xfer ? CNT_ONE : '0;
        end else if (err_xfer) begin
            ErrLane_DO <= ErrLane_DO | lane_err;
            ErrCnt_DO  <= (ErrCnt_DO == CNT_MAX) ? ErrCnt_DO : ErrCnt_DO + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_sbox_ced_pipe.sv
// tb_sbox_ced_pipe: scoreboard bench for sbox_ced_pipe. Expected words are
// queued at input handshake from an algebraic AES S-box model (GF inverse by
// search plus the affine rotation formula); a negedge monitor pops and
// compares on every output transfer and tracks the error counter model.
// Honours SBOX_CED_FAULT_INJ_EN when the DUT is built with it.

module tb_sbox_ced_pipe;

    localparam int LANES = 4;
    localparam int CNT_W = 2;
    localparam int W     = 8 * LANES;

    logic               Clk_CI = 1'b0;
    logic               Rst_RI = 1'b1;
    logic               InValid_SI = 1'b0;
    logic               InReady_SO;
    logic [W-1:0]       In_DI = '0;
    logic [LANES-1:0]   InPar_DI = '0;
    logic               OutValid_SO;
    logic               OutReady_SI = 1'b1;
    logic [W-1:0]       Out_DO;
    logic [LANES-1:0]   OutPar_DO;
    logic               Err_SO;
    logic [LANES-1:0]   ErrLane_DO;
    logic [CNT_W-1:0]   ErrCnt_DO;
    logic               ErrClr_SI = 1'b0;
`ifdef SBOX_CED_FAULT_INJ_EN
    logic [W-1:0]       FaultMask_DI = '0;
`endif

    always #5 Clk_CI = ~Clk_CI;

    sbox_ced_pipe #(.LANES(LANES), .CNT_W(CNT_W)) dut (
        .Clk_CI      (Clk_CI),
        .Rst_RI      (Rst_RI),
        .InValid_SI  (InValid_SI),
        .InReady_SO  (InReady_SO),
        .In_DI       (In_DI),
        .InPar_DI    (InPar_DI),
`ifdef SBOX_CED_FAULT_INJ_EN
        .FaultMask_DI(FaultMask_DI),
`endif
        .OutValid_SO (OutValid_SO),
        .OutReady_SI (OutReady_SI),
        .Out_DO      (Out_DO),
        .OutPar_DO   (OutPar_DO),
        .Err_SO      (Err_SO),
        .ErrLane_DO  (ErrLane_DO),
        .ErrCnt_DO   (ErrCnt_DO),
        .ErrClr_SI   (ErrClr_SI)
    );

    typedef struct packed {
        logic [W-1:0]     data;
        logic [LANES-1:0] par;
        logic [LANES-1:0] inerr;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] ref_sbox [256];
    int         checks = 0;
    int         passes = 0;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    bit         in_stream = 1'b0;

    always @(posedge Clk_CI) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        int p = 0;
        int x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = x << 1;
            if (x >= 256) x = x ^ 'h11b;
        end
        return 8'(p);
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    // S-box from its definition: multiplicative inverse found by search,
    // then the affine map b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    function automatic logic [7:0] sbox_model(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gf_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [LANES-1:0] par_of(input logic [W-1:0] d);
        logic [LANES-1:0] p;
        for (int l = 0; l < LANES; l++) p[l] = ^d[8*l +: 8];
        return p;
    endfunction

    // Offer one word; queue its expected result at the accepting edge.
    task automatic send_word(input logic [W-1:0] d, input logic [LANES-1:0] p, output bit first_try);
        exp_t e;
        bit   ok = 0;
        first_try = 0;
        InValid_SI = 1'b1;
        In_DI      = d;
        InPar_DI   = p;
        for (int k = 0; k < 200; k++) begin
            @(negedge Clk_CI);
            if (InReady_SO) begin
                for (int l = 0; l < LANES; l++) e.data[8*l +: 8] = ref_sbox[d[8*l +: 8]];
                e.par   = par_of(e.data);
                e.inerr = par_of(d) ^ p;
                sb_q.push_back(e);
                ok = 1;
                first_try = (k == 0);
                break;
            end
        end
        if (!ok) check_output("in_timeout", 0, 1);
        @(posedge Clk_CI) #1;
        InValid_SI = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [W-1:0] d, input logic [LANES-1:0] p);
        bit f;
        send_word(d, p, f);
    endtask

    task automatic drain();
        for (int k = 0; k < 300; k++) begin
            @(negedge Clk_CI);
            if (sb_q.size() == 0 && !OutValid_SO) break;
        end
        check_output("drain", sb_q.size(), 0);
        @(posedge Clk_CI) #1;
    endtask

    task automatic do_reset();
        Rst_RI = 1'b1;
        repeat (2) @(posedge Clk_CI);
        #1 Rst_RI = 1'b0;
    endtask

    task automatic pulse_clear();
        ErrClr_SI = 1'b1;
        @(posedge Clk_CI) #1;
        ErrClr_SI = 1'b0;
    endtask

    // Monitor: compares output transfers against the scoreboard and keeps a
    // reference model of the sticky lane flags and the saturating counter.
    logic [LANES-1:0] m_lane = '0;
    int               m_cnt = 0;
    bit               held = 0;
    logic [W-1:0]     held_data = '0;
    int               last_xfer = -1;
    always @(negedge Clk_CI) begin
        exp_t             e;
        logic [W-1:0]     mask_now;
        logic [LANES-1:0] exp_le;
        if (mon_en) begin
`ifdef SBOX_CED_FAULT_INJ_EN
            mask_now = FaultMask_DI;
`else
            mask_now = '0;
`endif
            if (Rst_RI) begin
                sb_q.delete();
                m_lane = '0;
                m_cnt = 0;
                held = 0;
                last_xfer = -1;
            end else begin
                check_output("err_lane", ErrLane_DO, m_lane);
                check_output("err_cnt", ErrCnt_DO, m_cnt);
                if (!OutValid_SO) check_output("err_idle", Err_SO, 0);
                if (held) begin
                    check_output("hold_valid", OutValid_SO, 1);
                    check_output("hold_data", Out_DO, held_data);
                end
                exp_le = '0;
                if (OutValid_SO && OutReady_SI) begin
                    if (sb_q.size() == 0) begin
                        check_output("spurious_out", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        for (int l = 0; l < LANES; l++)
                            exp_le[l] = e.inerr[l] | (^mask_now[8*l +: 8]);
                        check_output("out_data", Out_DO, e.data ^ mask_now);
                        check_output("out_par", OutPar_DO, e.par);
                        check_output("out_err", Err_SO, |exp_le);
                    end
                    if (in_stream) begin
                        if (last_xfer >= 0) check_output("stream_gap", cyc - last_xfer, 1);
                        last_xfer = cyc;
                    end
                end
                if (!in_stream) last_xfer = -1;
                if (ErrClr_SI) begin
                    m_lane = exp_le;
                    m_cnt  = (|exp_le) ? 1 : 0;
                end else if (|exp_le) begin
                    m_lane = m_lane | exp_le;
                    if (m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
                end
                held = OutValid_SO && !OutReady_SI;
                held_data = Out_DO;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit               f;
        int               nfirst;
        logic [W-1:0]     d;
        logic [LANES-1:0] bad;
        bit               done;

        for (int i = 0; i < 256; i++) ref_sbox[i] = sbox_model(8'(i));

        // Reset state
        do_reset();
        check_output("rst_out_valid", OutValid_SO, 0);
        check_output("rst_out_data", Out_DO, 0);
        check_output("rst_out_par", OutPar_DO, 0);
        check_output("rst_err", Err_SO, 0);
        check_output("rst_err_lane", ErrLane_DO, 0);
        check_output("rst_err_cnt", ErrCnt_DO, 0);
        check_output("rst_in_ready", InReady_SO, 1);
        mon_en = 1'b1;

        // Directed word with exact two-cycle latency
        apply_stimulus(32'h53_01_00_00, 4'b0100);
        @(negedge Clk_CI);
        check_output("lat_cycle1", OutValid_SO, 0);
        @(negedge Clk_CI);
        check_output("lat_cycle2", OutValid_SO, 1);
        check_output("dir_data", Out_DO, 32'hED_7C_63_63);
        check_output("dir_par", OutPar_DO, 4'b0100);
        check_output("dir_err", Err_SO, 0);
        drain();
        check_output("dir_cnt", ErrCnt_DO, 0);

        // All 256 byte values on lane 0, back-to-back
        in_stream = 1'b1;
        nfirst = 0;
        for (int i = 0; i < 256; i++) begin
            d = {24'($urandom), 8'(i)};
            send_word(d, par_of(d), f);
            if (f) nfirst++;
        end
        drain();
        in_stream = 1'b0;
        check_output("stream_no_stall", nfirst, 256);

        // Backpressure: three words offered while output is stalled
        OutReady_SI = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    d = $urandom;
                    apply_stimulus(d, par_of(d));
                end
            end
            begin
                repeat (5) @(negedge Clk_CI);
                check_output("hold_in_ready", InReady_SO, 0);
                check_output("hold_accepted", sb_q.size(), 2);
                @(posedge Clk_CI) #1;
                OutReady_SI = 1'b1;
            end
        join
        drain();

        // Input parity fault on lane 2, held before acceptance
        pulse_clear();
        OutReady_SI = 1'b0;
        apply_stimulus(32'h00_01_00_00, 4'b0000);
        repeat (4) @(posedge Clk_CI);
        #1 OutReady_SI = 1'b1;
        drain();
        check_output("pfault_cnt", ErrCnt_DO, 1);
        check_output("pfault_lane", ErrLane_DO, 4'b0100);

        // Counter saturation, then clear coinciding with an error transfer
        pulse_clear();
        for (int i = 0; i < 5; i++) begin
            d = $urandom;
            apply_stimulus(d, par_of(d) ^ 4'b0001);
        end
        drain();
        check_output("sat_cnt", ErrCnt_DO, 3);
        d = $urandom;
        apply_stimulus(d, par_of(d) ^ 4'b1000);
        @(posedge Clk_CI) #1;
        ErrClr_SI = 1'b1;
        @(posedge Clk_CI) #1;
        ErrClr_SI = 1'b0;
        check_output("clr_xfer_cnt", ErrCnt_DO, 1);
        check_output("clr_xfer_lane", ErrLane_DO, 4'b1000);
        drain();

`ifdef SBOX_CED_FAULT_INJ_EN
        // Fault injection: odd-weight mask detected, even-weight mask not
        pulse_clear();
        FaultMask_DI = 32'h0000_0100;
        apply_stimulus(32'h0, 4'b0000);
        @(negedge Clk_CI);
        @(negedge Clk_CI);
        check_output("fi_data", Out_DO, 32'h63_63_62_63);
        check_output("fi_par", OutPar_DO, 4'b0000);
        check_output("fi_err", Err_SO, 1);
        drain();
        check_output("fi_lane", ErrLane_DO, 4'b0010);
        pulse_clear();
        FaultMask_DI = 32'h0000_0300;
        apply_stimulus(32'h0, 4'b0000);
        drain();
        check_output("fi_even_cnt", ErrCnt_DO, 0);
        FaultMask_DI = '0;
`endif

        // Randomised traffic with backpressure, parity faults and clears
        done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    d = $urandom;
                    bad = '0;
                    for (int l = 0; l < LANES; l++) bad[l] = ($urandom_range(0, 7) == 0);
                    apply_stimulus(d, par_of(d) ^ bad);
                    if ($urandom_range(0, 3) == 0) @(posedge Clk_CI) #1;
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge Clk_CI) #1;
                    OutReady_SI = ($urandom_range(0, 3) != 0);
                    ErrClr_SI   = ($urandom_range(0, 15) == 0);
                end
                OutReady_SI = 1'b1;
                ErrClr_SI   = 1'b0;
            end
        join
        drain();

        // Reset with erroneous words in flight: nothing counted or delivered
        OutReady_SI = 1'b0;
        apply_stimulus(32'h11_22_33_44, 4'b1111);
        apply_stimulus(32'h55_66_77_88, 4'b1111);
        do_reset();
        OutReady_SI = 1'b1;
        check_output("midrst_valid", OutValid_SO, 0);
        check_output("midrst_cnt", ErrCnt_DO, 0);
        check_output("midrst_in_ready", InReady_SO, 1);
        d = $urandom;
        apply_stimulus(d, par_of(d));
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sbox_ced_pipe.md
Name: sbox_ced_pipe

Overview:
- Multi-lane, pipelined AES forward S-box substitution unit with concurrent error detection (CED).
- Parametrised successor to the single-byte combinational S-box with output parity. Substitutes LANES bytes per cycle behind a valid/ready handshake.
- Checks the parity of each input byte and predicts the parity of each output byte from an independent table, so a fault in either the lookup or the datapath is flagged.
- Sits between the round-state register and ShiftRows in the protected AES datapath. Error outputs feed the CED alarm logic.

Parameters:
- LANES, 4, number of byte lanes processed in parallel (1..16; 16 = full AES state).
- CNT_W, 8, width of the saturating error-event counter.

Ports:
- Clk_CI  in  1  clock, all logic on rising edge.
- Rst_RI  in  1  synchronous active-high reset.
- InValid_SI  in  1  input word valid.
- InReady_SO  out  1  unit can accept input this cycle.
- In_DI  in  8*LANES  input bytes, lane i = bits [8i+7:8i].
- InPar_DI  in  LANES  even parity bit per input byte.
- OutValid_SO  out  1  output word valid.
- OutReady_SI  in  1  downstream accepts output.
- Out_DO  out  8*LANES  substituted bytes, lane-aligned with In_DI.
- OutPar_DO  out  LANES  predicted even parity per output byte.
- Err_SO  out  1  current output word has at least one lane error (qualified by OutValid_SO).
- ErrLane_DO  out  LANES  sticky per-lane error flags.
- ErrCnt_DO  out  CNT_W  saturating count of erroneous words transferred.
- ErrClr_SI  in  1  clears ErrLane_DO and ErrCnt_DO.

Behaviour:
- Parity convention is even: parity bit = XOR of the 8 data bits.
- Pipeline has two register stages, S1 and S2.
  - S1 captures In_DI, InPar_DI and per-lane input check inErr[i] = (^byte_i) ^ InPar_DI[i].
  - S2 captures SBOX(S1 byte_i), the predicted parity bit PPAR(S1 byte_i) and S1 inErr.
- PPAR is a separate 256x1 table holding parity(SBOX(x)). It must not be derived from the SBOX output.
- Outputs:
  - Out_DO = S2 bytes.
  - OutPar_DO = S2 predicted parity.
  - laneErr[i] = S2 inErr[i] | ((^Out_DO lane i) ^ OutPar_DO[i]).
  - Err_SO = OutValid_SO & |laneErr.
- Latency is exactly 2 cycles from input handshake to OutValid_SO when there is no backpressure. Throughput is 1 word per cycle.
- Handshake:
  - Transfer occurs when valid & ready are both high in the same cycle.
  - s2_hold = OutValid_SO & ~OutReady_SI.
  - InReady_SO = ~s1_valid | ~s2_hold (combinational from OutReady_SI).
  - S2 loads from S1 when ~s2_hold. S1 loads from input when InReady_SO.
  - A stage's valid clears when it advances and has no new data.
  - Held stages keep data stable and OutValid_SO stays high until accepted.
  - Valid/data must never drop without an accepting handshake.
- Error accounting happens on output transfer only (OutValid_SO & OutReady_SI & Err_SO):
  - ErrLane_DO |= laneErr.
  - ErrCnt_DO increments by 1 and saturates at 2^CNT_W-1 (no wrap).
  - A held erroneous word is counted once.
- ErrClr_SI:
  - Clears ErrLane_DO and ErrCnt_DO.
  - If it coincides with a counted error transfer, the result is ErrLane_DO = laneErr and ErrCnt_DO = 1.
- Reset: OutValid_SO=0, s1_valid=0, Out_DO=0, OutPar_DO=0, ErrLane_DO=0, ErrCnt_DO=0, Err_SO=0.
  - InReady_SO=1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight words without counting them.

Optional Feature:
- Macro SBOX_CED_FAULT_INJ_EN.
- When defined:
  - Adds input FaultMask_DI, 8*LANES bits.
  - The mask is XORed into the S2 byte value before it drives Out_DO and before the parity check.
  - OutPar_DO is unaffected, so any odd-weight mask lane produces laneErr.
  - Used for bench and silicon alarm-path testing.
- When undefined: no port, and Out_DO = S2 bytes directly.

Test Plan:
- Reset, then LANES=4, In_DI=32'h53_01_00_00, InPar_DI=4'b0100, OutReady_SI=1.
  - Expect OutValid_SO two cycles after the handshake, Out_DO=32'hED_7C_63_63, OutPar_DO=4'b0100, Err_SO=0, ErrCnt_DO=0.
- Stream 256 words, lane 0 = 0x00..0xFF, each with correct parity, back-to-back.
  - Expect each Out_DO matching the AES S-box (e.g. 0x0B->0x2B, 0xFF->0x16), no bubbles, no errors.
- Hold OutReady_SI=0 for 5 cycles with 3 words offered.
  - InReady_SO drops after 2 words are accepted, Out_DO is stable, and no word is lost or duplicated on release.
- Input parity fault: In_DI lane 2 = 0x01 with InPar_DI[2]=0.
  - On transfer: Err_SO=1, ErrLane_DO=4'b0100, ErrCnt_DO=1.
  - Hold OutReady_SI low 3 cycles first: count still 1.
- Saturation with CNT_W=2: 5 erroneous transfers give ErrCnt_DO=3.
  - ErrClr_SI asserted with a 6th error transfer gives ErrCnt_DO=1.
- With SBOX_CED_FAULT_INJ_EN, FaultMask_DI lane 1 = 0x01 and input 0x00.
  - Out_DO lane 1 = 0x62, OutPar_DO[1]=0, Err_SO=1, ErrLane_DO[1]=1.
  - Mask 0x03 changes data undetected (documented even-weight limitation).
